ghost_collision_ctrl: RTL

//   Downstream consumer of the ghost movers' x/y outputs and the pacman position.

---
 rtl/ghost_collision_ctrl_if.sv | 26 ++
 rtl/ghost_collision_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/ghost_collision_ctrl_if.sv
// Bundle between the collision controller, the sprite movers and the HUD.
// master: drives frame strobe, restart request and sprite positions.
// slave : the collision controller; returns hit/freeze/respawn/status.
interface ghost_collision_ctrl_if;
  logic       frame_stb;
  logic       start;
  logic [8:0] x_pac;
  logic [8:0] y_pac;
  logic [8:0] x_ghost;
  logic [8:0] y_ghost;
  logic       hit;
  logic       freeze;
  logic       respawn;
  logic       game_over;
  logic [2:0] lives;

  modport master (
    output frame_stb, start, x_pac, y_pac, x_ghost, y_ghost,
    input  hit, freeze, respawn, game_over, lives
  );

  modport slave (
    input  frame_stb, start, x_pac, y_pac, x_ghost, y_ghost,
    output hit, freeze, respawn, game_over, lives
  );
endinterface

// File: rtl/ghost_collision_ctrl.sv
// Pacman/ghost collision checker and life/death/respawn game FSM.
// Once per frame_stb the sprite boxes are compared; a hit costs a life,
// freezes the movers for DEATH_FRAMES frames, then pulses respawn (or
// parks in GAME_OVER when no lives remain). All outputs are registered.
// Optional feature macro: COLLISION_GRACE_EN -- post-respawn invulnerability
// for GRACE_FRAMES frames. Without it the grace counter is a constant 0.
module ghost_collision_ctrl #(
  parameter int HIT_DIST     = 8,
  parameter int START_LIVES  = 3,
  parameter int DEATH_FRAMES = 60,
  parameter int GRACE_FRAMES = 120
) (
  input  logic                  vga_pix_clk,
  input  logic                  rst_n,
  ghost_collision_ctrl_if.slave bus
);

  localparam int CW = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;
  localparam int GW = (GRACE_FRAMES > 0) ? $clog2(GRACE_FRAMES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEATH_FRAMES - 1);
  localparam logic [2:0]    LIVES_INIT = 3'(START_LIVES);

  typedef enum logic [1:0] {PLAY, DYING, RESPAWN, GAME_OVER} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    lives_q, lives_d;
  logic          hit_q, hit_d;
  logic          freeze_q, freeze_d;
  logic          respawn_q, respawn_d;
  logic          game_over_q, game_over_d;
  logic [GW-1:0] grace_cnt;

  // Per-axis distance; 10-bit signed so the 9-bit positions never wrap.
  logic signed [9:0] dx, dy;
  logic [9:0]        adx, ady;
  logic              overlap, hit_cond;

  assign dx  = $signed({1'b0, bus.x_pac}) - $signed({1'b0, bus.x_ghost});
  assign dy  = $signed({1'b0, bus.y_pac}) - $signed({1'b0, bus.y_ghost});
  assign adx = dx[9] ? (~dx + 10'd1) : dx;
  assign ady = dy[9] ? (~dy + 10'd1) : dy;
  assign overlap  = (adx < 10'(HIT_DIST)) && (ady < 10'(HIT_DIST));
  assign hit_cond = bus.frame_stb && overlap && (grace_cnt == '0);

`ifdef COLLISION_GRACE_EN
  logic [GW-1:0] grace_q, grace_d;
  assign grace_cnt = grace_q;

  // Grace counter: loaded on every return to PLAY, burns down per frame.
  always_comb begin
    grace_d = grace_q;
    if (state_q == RESPAWN)
      grace_d = GW'(GRACE_FRAMES);
    else if (state_q == PLAY && bus.frame_stb && grace_q != '0)
      grace_d = grace_q - GW'(1);
  end

  // Grace counter register.
  always_ff @(posedge vga_pix_clk or negedge rst_n) begin
    if (!rst_n) grace_q <= '0;
    else        grace_q <= grace_d;
  end
`else
  assign grace_cnt = '0;
`endif

  // State, counter, lives and registered outputs.
  always_ff @(posedge vga_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PLAY;
      cnt_q       <= '0;
      lives_q     <= LIVES_INIT;
      hit_q       <= 1'b0;
      freeze_q    <= 1'b0;
      respawn_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lives_q     <= lives_d;
      hit_q       <= hit_d;
      freeze_q    <= freeze_d;
      respawn_q   <= respawn_d;
      game_over_q <= game_over_d;
    end
  end

  // Next-state: game FSM plus death-frame counter and lives bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lives_d = lives_q;
    case (state_q)
      PLAY: begin
        if (hit_cond) begin
          state_d = DYING;
          lives_d = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
          cnt_d   = '0;
        end
      end
      DYING: begin
        if (bus.frame_stb) begin
          if (cnt_q == CNT_LAST)
            state_d = (lives_q == 3'd0) ? GAME_OVER : RESPAWN;
          else
            cnt_d = cnt_q + CW'(1);
        end
      end
      RESPAWN: state_d = PLAY;
      GAME_OVER: begin
        // start takes priority over any coincident frame strobe.
        if (bus.start) begin
          lives_d = LIVES_INIT;
          state_d = RESPAWN;
        end
      end
      default: state_d = PLAY;
    endcase
  end

  // Output decode from the upcoming state so outputs track state changes.
  always_comb begin
    hit_d       = (state_q == PLAY) && hit_cond;
    freeze_d    = (state_d == DYING) || (state_d == GAME_OVER);
    respawn_d   = (state_d == RESPAWN);
    game_over_d = (state_d == GAME_OVER);
  end

  assign bus.hit       = hit_q;
  assign bus.freeze    = freeze_q;
  assign bus.respawn   = respawn_q;
  assign bus.game_over = game_over_q;
  assign bus.lives     = lives_q;

endmodule
